regfile_spi_streamer: RTL

//  Sequences read port 1 of the CPU register file and streams a contiguous (wrapping) range
//  of registers out over a write-only SPI master link (mode 0, MSB first).

---
 rtl/regfile_spi_streamer_pkg.sv | 20 ++
 rtl/regfile_spi_streamer_if.sv | 27 ++
 rtl/regfile_spi_streamer_spi_tx.sv | 62 ++++++
 rtl/regfile_spi_streamer.sv | 106 ++++++++++
 4 files changed

// File: rtl/regfile_spi_streamer_pkg.sv
// Shared widths and FSM encoding for the register-file SPI dump path.
package regfile_spi_streamer_pkg;

  localparam int W_CPU = 32;
  localparam int W_REG = 5;

  typedef enum logic [2:0] {
    SPI_ST_IDLE  = 3'd0,
    SPI_ST_LOAD  = 3'd1,
    SPI_ST_SHIFT = 3'd2,
    SPI_ST_NEXT  = 3'd3,
    SPI_ST_FIN   = 3'd4
  } spi_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_spi_streamer_if.sv
// Control, register-file read port and SPI pins of the streamer as one bundle.
interface regfile_spi_streamer_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
);
  logic              start;
  logic [W_ADDR-1:0] first_reg;
  logic [W_ADDR-1:0] last_reg;
  logic              busy;
  logic [W_ADDR-1:0] rf_ra;
  logic [W_DATA-1:0] rf_rd;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              dv_spi;
  logic              done;

  modport master (
    input  start, first_reg, last_reg, rf_rd,
    output busy, rf_ra, cs_n, sclk, mosi, dv_spi, done
  );

  modport slave (
    output start, first_reg, last_reg, rf_rd,
    input  busy, rf_ra, cs_n, sclk, mosi, dv_spi, done
  );
endinterface

// File: rtl/regfile_spi_streamer_spi_tx.sv
// SPI mode-0 word transmitter: SCLK divider, MSB-first shift register, bit counter.
module regfile_spi_streamer_spi_tx
  import regfile_spi_streamer_pkg::*;
#(
  parameter int W_DATA  = W_CPU,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_DATA-1:0] data_in,
  output logic              busy,
  output logic              word_done,
  output logic              sclk,
  output logic              mosi
);
  localparam int W_DIV = cnt_w(CLK_DIV);
  localparam int W_BIT = cnt_w(W_DATA);
  localparam logic [W_DIV-1:0] DIV_MAX = W_DIV'(CLK_DIV - 1);
  localparam logic [W_BIT-1:0] BIT_MAX = W_BIT'(W_DATA - 1);

  logic [W_DIV-1:0]  div;
  logic [W_BIT-1:0]  bit_cnt;
  logic [W_DATA-1:0] sh;
  logic              tick;

  // The MSB of the shift register is the bit on the wire, so mosi is a flop output.
  assign mosi      = sh[W_DATA-1];
  assign tick      = busy && (div == '0);
  assign word_done = tick && sclk && (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      sclk    <= 1'b0;
    end else if (load) begin
      busy    <= 1'b1;
      div     <= DIV_MAX;
      bit_cnt <= BIT_MAX;
      sh      <= data_in;
      sclk    <= 1'b0;
    end else if (tick) begin
      div  <= DIV_MAX;
      sclk <= ~sclk;
      // Data only moves on the falling toggle; the slave samples on the rise.
      if (sclk) begin
        if (bit_cnt == '0) begin
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
          sh      <= {sh[W_DATA-2:0], 1'b0};
        end
      end
    end else if (busy) begin
      div <= div - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_spi_streamer.sv
// Walks a wrapping register range through read port 1 and streams each word out over SPI.
module regfile_spi_streamer
  import regfile_spi_streamer_pkg::*;
#(
  parameter int W_DATA  = W_CPU,
  parameter int W_ADDR  = W_REG,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_spi_streamer_if.master bus
);
  spi_state_e        state, state_nx;
  logic [W_ADDR-1:0] ptr;
  logic [W_ADDR-1:0] last;
  logic              load;
  logic              advance;
  logic              tx_busy;
  logic              word_done;
  logic [W_DATA-1:0] word;

  // Register 0 is architecturally zero regardless of what the array returns.
  assign word = (ptr == '0) ? '0 : bus.rf_rd;

  regfile_spi_streamer_spi_tx #(
    .W_DATA  (W_DATA),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (word),
    .busy      (tx_busy),
    .word_done (word_done),
    .sclk      (bus.sclk),
    .mosi      (bus.mosi)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= SPI_ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    advance  = 1'b0;
    case (state)
      SPI_ST_IDLE:  if (bus.start) state_nx = SPI_ST_LOAD;
      SPI_ST_LOAD: begin
        load     = 1'b1;
        state_nx = SPI_ST_SHIFT;
      end
      SPI_ST_SHIFT: if (word_done || !tx_busy) state_nx = SPI_ST_NEXT;
      SPI_ST_NEXT: begin
        if (ptr == last) begin
          state_nx = SPI_ST_FIN;
        end else begin
          advance  = 1'b1;
          state_nx = SPI_ST_LOAD;
        end
      end
      SPI_ST_FIN:   state_nx = SPI_ST_IDLE;
      default:      state_nx = SPI_ST_IDLE;
    endcase
  end

  // rf_ra is loaded one cycle ahead so the array output is settled during LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      last       <= '0;
      bus.rf_ra  <= '0;
      bus.busy   <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.dv_spi <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.dv_spi <= (state == SPI_ST_SHIFT) && (state_nx == SPI_ST_NEXT);
      bus.done   <= (state == SPI_ST_FIN);
      case (state)
        SPI_ST_IDLE: begin
          if (bus.start) begin
            ptr       <= bus.first_reg;
            last      <= bus.last_reg;
            bus.rf_ra <= bus.first_reg;
            bus.busy  <= 1'b1;
          end
        end
        SPI_ST_LOAD: bus.cs_n <= 1'b0;
        SPI_ST_NEXT: begin
          if (advance) begin
            ptr       <= ptr + 1'b1;
            bus.rf_ra <= ptr + 1'b1;
          end
        end
        SPI_ST_FIN: begin
          bus.cs_n <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
